// File: rtl/uart_frame_loader.sv
// Parses a framed image upload from the UART byte stream (sync, 16-bit W/H header,
// pixel payload, XOR checksum) and writes pixels row-major into the image buffer.
module uart_frame_loader #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned MAX_WIDTH      = 256,
  parameter int unsigned MAX_HEIGHT     = 256,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              rx_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [15:0]       img_width,
  output logic [15:0]       img_height,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {StIdle, StHdr, StPix, StChk} state_e;

  localparam logic [1:0] ErrDim      = 2'd1;
  localparam logic [1:0] ErrChecksum = 2'd2;
  localparam logic [1:0] ErrTimeout  = 2'd3;

  localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [31:0] pix_idx_q, pix_idx_d;
  logic [31:0] pix_total_q, pix_total_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] tmo_q, tmo_d;

  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic [15:0]       img_width_d, img_height_d;
  logic              busy_d, frame_done_d, frame_err_d;
  logic [1:0]        err_code_d;

  logic [15:0] hdr_h;

  always_comb begin
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    pix_idx_d    = pix_idx_q;
    pix_total_d  = pix_total_q;
    csum_d       = csum_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    img_width_d  = img_width;
    img_height_d = img_height;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code;
    hdr_h        = {rx_byte, img_height[7:0]};

    // Any received byte restarts the inter-byte timer.
    if (state_q == StIdle || rx_done) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_done && rx_byte == SYNC_BYTE) begin
          state_d   = StHdr;
          hdr_idx_d = 2'd0;
        end
      end

      StHdr: begin
        if (rx_done) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          unique case (hdr_idx_q)
            2'd0: img_width_d[7:0]   = rx_byte;
            2'd1: img_width_d[15:8]  = rx_byte;
            2'd2: img_height_d[7:0]  = rx_byte;
            2'd3: img_height_d[15:8] = rx_byte;
            default: ;
          endcase
          if (hdr_idx_q == 2'd3) begin
            if (img_width == 16'd0 || hdr_h == 16'd0 ||
                {16'd0, img_width} > MAX_WIDTH || {16'd0, hdr_h} > MAX_HEIGHT) begin
              state_d     = StIdle;
              frame_err_d = 1'b1;
              err_code_d  = ErrDim;
            end else begin
              state_d     = StPix;
              pix_total_d = 32'(img_width) * 32'(hdr_h);
              pix_idx_d   = '0;
              mem_addr_d  = '0;
              csum_d      = '0;
            end
          end
        end
      end

      StPix: begin
        if (rx_done) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = pix_idx_q[ADDR_W-1:0];
          mem_wdata_d = rx_byte;
          csum_d      = csum_q ^ rx_byte;
          pix_idx_d   = pix_idx_q + 32'd1;
          if (pix_idx_q == pix_total_q - 32'd1) begin
            state_d = StChk;
          end
        end
      end

      StChk: begin
        if (rx_done) begin
          state_d = StIdle;
          if (rx_byte == csum_q) begin
            frame_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ErrChecksum;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // A byte arriving on the expiry cycle takes precedence over the timeout.
    if (state_q != StIdle && !rx_done && tmo_q == TmoLast) begin
      state_d     = StIdle;
      frame_err_d = 1'b1;
      err_code_d  = ErrTimeout;
      tmo_d       = '0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hdr_idx_q   <= '0;
      pix_idx_q   <= '0;
      pix_total_q <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      img_width   <= '0;
      img_height  <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      pix_idx_q   <= pix_idx_d;
      pix_total_q <= pix_total_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      img_width   <= img_width_d;
      img_height  <= img_height_d;
      busy        <= busy_d;
      frame_done  <= frame_done_d;
      frame_err   <= frame_err_d;
      err_code    <= err_code_d;
    end
  end

endmodule
